// File: rtl/fb_stream_reader_pkg.sv
// Shared constants and types for the 8-bit pixel stream and the frame-buffer reader.
// Imported by fb_stream_reader and its output FIFO.
package fb_stream_reader_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned FRAME_W = 160;
   localparam int unsigned FRAME_H = 120;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2
   } state_e;

   // One stream beat as stored in the output FIFO.
   typedef struct packed {
      logic [PIX_W-1:0] pixel;
      logic             sof;
      logic             eol;
   } stream_beat_t;

   localparam int unsigned BEAT_W = PIX_W + 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO for stream beats; the head entry is a register that drives the
// stream outputs directly, so the outputs stay stable while the consumer stalls.
module stream_fifo2
   import fb_stream_reader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [BEAT_W-1:0] din,
   input  logic              pop,
   output logic [BEAT_W-1:0] head,
   output logic [1:0]        count,
   output logic              full,
   output logic              empty
);

   logic [BEAT_W-1:0] head_q;
   logic [BEAT_W-1:0] tail_q;
   logic [1:0]        count_q;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= din;
               else                 tail_q <= din;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; the new beat lands behind whatever remains.
               if (count_q == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = head_q;
   assign count = count_q;
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fb_stream_reader.sv
// Frame-buffer read-out source: walks a W x H frame in raster order through a 1-cycle
// synchronous RAM port and emits it as a valid/ready pixel stream tagged with sof/eol.
module fb_stream_reader
   import fb_stream_reader_pkg::*;
#(
   parameter int unsigned W          = FRAME_W,
   parameter int unsigned H          = FRAME_H,
   parameter int unsigned ADDR_W     = 15,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pixel,
   output logic              out_sof,
   output logic              out_eol
);

   localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;
   localparam logic [XW-1:0] XLast = XW'(W - 1);
   localparam logic [YW-1:0] YLast = YW'(H - 1);

   state_e            state_q, state_d;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [YW-1:0]     out_y_q;
   logic [ADDR_W-1:0] addr_q;
   logic              inflight_q;
   logic              tag_sof_q;
   logic              tag_eol_q;
   logic              done_q;

   logic              pop;
   logic              issue;
   logic              accept;
   logic              line_end;
   logic              last_issue;
   logic              last_pop;
   logic [2:0]        occ;

   stream_beat_t      push_beat;
   stream_beat_t      head_beat;
   logic [BEAT_W-1:0] fifo_head;
   logic [1:0]        fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   assign pop = out_valid && out_ready;

   // Reads in flight plus beats already buffered may never exceed the two FIFO slots.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign issue = (state_q == StIssue) && (occ < (3'd2 + {2'b00, pop}));

   assign line_end   = (x_q == XLast);
   assign last_issue = issue && line_end && (y_q == YLast);
   assign last_pop   = pop && out_eol && (out_y_q == YLast);

   // frame_done cycle is still part of the finished frame, so a start there is dropped.
   assign accept = (state_q == StIdle) && start && !done_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StIssue;
         // Continuous mode wraps straight into the next frame so the stream has no gap.
         StIssue: if (last_issue && !CONTINUOUS) state_d = StDrain;
         StDrain: if (last_pop) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         out_y_q    <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         tag_sof_q  <= 1'b0;
         tag_eol_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         done_q     <= last_pop;
         if (accept) begin
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            out_y_q <= '0;
         end else begin
            if (issue) begin
               tag_sof_q <= (x_q == '0) && (y_q == '0);
               tag_eol_q <= line_end;
               addr_q    <= last_issue ? '0 : addr_q + 1'b1;
               x_q       <= line_end ? '0 : x_q + 1'b1;
               if (line_end) y_q <= (y_q == YLast) ? '0 : y_q + 1'b1;
            end
            if (pop && out_eol) out_y_q <= (out_y_q == YLast) ? '0 : out_y_q + 1'b1;
         end
      end
   end

   assign push_beat = '{pixel: rd_data, sof: tag_sof_q, eol: tag_eol_q};

   stream_fifo2 u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight_q),
      .din   (push_beat),
      .pop   (pop),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_beat = fifo_head;

   no_overflow_a: assert property (@(posedge clk) disable iff (reset)
      !(fifo_full && inflight_q && !pop));

   assign busy       = (state_q != StIdle);
   assign frame_done = done_q;
   assign rd_en      = issue;
   assign rd_addr    = addr_q;
   assign out_valid  = !fifo_empty;
   assign out_pixel  = head_beat.pixel;
   assign out_sof    = head_beat.sof;
   assign out_eol    = head_beat.eol;

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader on a 4x3 frame whose RAM holds value == address.
// A second instance with CONTINUOUS=1 covers back-to-back frames.
module tb_fb_stream_reader;

   logic       clk;
   logic       reset;
   logic       start, out_ready;
   logic       busy, frame_done, rd_en, out_valid, out_sof, out_eol;
   logic [3:0] rd_addr;
   logic [7:0] rd_data, out_pixel;

   logic       start_c, ready_c;
   logic       busy_c, frame_done_c, rd_en_c, out_valid_c, out_sof_c, out_eol_c;
   logic [3:0] rd_addr_c;
   logic [7:0] rd_data_c, out_pixel_c;

   int n_checks = 0;
   int n_fail   = 0;

   fb_stream_reader #(.W(4), .H(3), .ADDR_W(4), .CONTINUOUS(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pixel  (out_pixel),
      .out_sof    (out_sof),
      .out_eol    (out_eol)
   );

   fb_stream_reader #(.W(4), .H(3), .ADDR_W(4), .CONTINUOUS(1'b1)) dut_c (
      .clk        (clk),
      .reset      (reset),
      .start      (start_c),
      .busy       (busy_c),
      .frame_done (frame_done_c),
      .rd_en      (rd_en_c),
      .rd_addr    (rd_addr_c),
      .rd_data    (rd_data_c),
      .out_valid  (out_valid_c),
      .out_ready  (ready_c),
      .out_pixel  (out_pixel_c),
      .out_sof    (out_sof_c),
      .out_eol    (out_eol_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM models, contents equal to the address.
   always @(posedge clk) begin
      if (rd_en)   rd_data   <= {4'h0, rd_addr};
      if (rd_en_c) rd_data_c <= {4'h0, rd_addr_c};
   end

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; start_c = 1'b0; ready_c = 1'b0;
      #3;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (out_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof got %b want 0", out_sof); end
      n_checks++; if (out_eol !== 1'b0) begin n_fail++; $display("FAIL reset_eol got %b want 0", out_eol); end
      n_checks++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", rd_addr); end
      n_checks++; if (out_pixel !== 8'd0) begin n_fail++; $display("FAIL reset_pixel got %0d want 0", out_pixel); end
      n_checks++; if (out_valid_c !== 1'b0) begin n_fail++; $display("FAIL reset_valid_c got %b want 0", out_valid_c); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_full_rate();
      int n, first_t, last_t, done_t, done_cnt;
      logic busy_at_done, busy_t1;
      n = 0; first_t = -1; last_t = -1; done_t = -1; done_cnt = 0;
      busy_at_done = 1'bx; busy_t1 = 1'bx;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         #1;
         if (t == 1) busy_t1 = busy;
         if (frame_done) begin
            done_cnt++;
            if (done_t < 0) begin done_t = t; busy_at_done = busy; end
         end
         if (out_valid && out_ready) begin
            n_checks++; if (out_pixel !== n[7:0]) begin n_fail++; $display("FAIL full_pixel got %0d want %0d", out_pixel, n); end
            n_checks++; if (out_sof !== (n == 0)) begin n_fail++; $display("FAIL full_sof n=%0d got %b", n, out_sof); end
            n_checks++; if (out_eol !== (n % 4 == 3)) begin n_fail++; $display("FAIL full_eol n=%0d got %b", n, out_eol); end
            if (n > 0) begin
               n_checks++; if (t != last_t + 1) begin n_fail++; $display("FAIL full_gap n=%0d at %0d want %0d", n, t, last_t + 1); end
            end
            if (n == 0) first_t = t;
            last_t = t; n++;
         end
         @(posedge clk); #1;
      end
      n_checks++; if (busy_t1 !== 1'b1) begin n_fail++; $display("FAIL full_busy_on got %b want 1", busy_t1); end
      n_checks++; if (first_t != 3) begin n_fail++; $display("FAIL full_latency got %0d want 3", first_t); end
      n_checks++; if (n != 12) begin n_fail++; $display("FAIL full_count got %0d want 12", n); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt got %0d want 1", done_cnt); end
      n_checks++; if (done_t != last_t + 1) begin n_fail++; $display("FAIL full_done_t got %0d want %0d", done_t, last_t + 1); end
      n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL full_busy_drop got %b want 0", busy_at_done); end
   endtask

   task automatic test_backpressure();
      int n, done_cnt, outst;
      logic [3:0] pat;
      logic prev_stall, prev_sof, prev_eol;
      logic [7:0] prev_pix;
      pat = 4'b1001; n = 0; done_cnt = 0; outst = 0; prev_stall = 1'b0;
      prev_pix = '0; prev_sof = 1'b0; prev_eol = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 0; k < 80; k++) begin
         out_ready = pat[k % 4];
         #1;
         if (frame_done) done_cnt++;
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pixel !== prev_pix || out_sof !== prev_sof || out_eol !== prev_eol) begin
               n_fail++;
               $display("FAIL bp_stable got v=%b p=%0d want v=1 p=%0d", out_valid, out_pixel, prev_pix);
            end
         end
         outst = outst + (rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         if (outst > 2) begin
            n_checks++; n_fail++;
            $display("FAIL bp_credit outstanding got %0d want <=2", outst);
         end
         if (out_valid && out_ready) begin
            n_checks++; if (out_pixel !== n[7:0]) begin n_fail++; $display("FAIL bp_pixel got %0d want %0d", out_pixel, n); end
            n++;
         end
         prev_stall = out_valid && !out_ready;
         prev_pix = out_pixel; prev_sof = out_sof; prev_eol = out_eol;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      n_checks++; if (n != 12) begin n_fail++; $display("FAIL bp_count got %0d want 12", n); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_stall_start();
      int reads, n, last_t, done_cnt;
      reads = 0; n = 0; last_t = -1; done_cnt = 0;
      out_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         #1;
         if (rd_en) reads++;
         @(posedge clk); #1;
      end
      #1;
      n_checks++; if (reads != 2) begin n_fail++; $display("FAIL stall_reads got %0d want 2", reads); end
      n_checks++; if (out_valid !== 1'b1 || out_pixel !== 8'd0) begin n_fail++; $display("FAIL stall_hold got v=%b p=%0d want v=1 p=0", out_valid, out_pixel); end
      #1;
      for (int t = 21; t <= 50; t++) begin
         out_ready = 1'b1;
         #1;
         if (frame_done) done_cnt++;
         if (out_valid && out_ready) begin
            n_checks++; if (out_pixel !== n[7:0]) begin n_fail++; $display("FAIL stall_pixel got %0d want %0d", out_pixel, n); end
            if (n >= 2) begin
               n_checks++; if (t != last_t + 1) begin n_fail++; $display("FAIL stall_gap n=%0d at %0d want %0d", n, t, last_t + 1); end
            end
            last_t = t; n++;
         end
         @(posedge clk); #1;
      end
      n_checks++; if (n != 12) begin n_fail++; $display("FAIL stall_count got %0d want 12", n); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      int n, done_cnt;
      n = 0; done_cnt = 0;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 1; t <= 45; t++) begin
         start = frame_done || (out_valid && (out_pixel == 8'd5 || out_pixel == 8'd11));
         #1;
         if (frame_done) done_cnt++;
         if (out_valid && out_ready) begin
            n_checks++; if (out_pixel !== n[7:0]) begin n_fail++; $display("FAIL ign_pixel got %0d want %0d", out_pixel, n); end
            n++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_checks++; if (n != 12) begin n_fail++; $display("FAIL ign_count got %0d want 12", n); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy got %b want 0", busy); end
   endtask

   task automatic test_continuous();
      int n, last_t, done_cnt, sof_cnt;
      n = 0; last_t = -1; done_cnt = 0; sof_cnt = 0;
      ready_c = 1'b1; start_c = 1'b1;
      @(posedge clk); #1 start_c = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         #1;
         if (frame_done_c) done_cnt++;
         if (n == 24) break;
         n_checks++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL cont_busy t=%0d got %b want 1", t, busy_c); end
         if (out_valid_c && ready_c) begin
            n_checks++; if (out_pixel_c !== 8'(n % 12)) begin n_fail++; $display("FAIL cont_pixel got %0d want %0d", out_pixel_c, n % 12); end
            n_checks++; if (out_eol_c !== (n % 4 == 3)) begin n_fail++; $display("FAIL cont_eol n=%0d got %b", n, out_eol_c); end
            if (out_sof_c) begin
               sof_cnt++;
               n_checks++; if (n % 12 != 0) begin n_fail++; $display("FAIL cont_sof_pos got %0d want 0 or 12", n); end
            end
            if (n > 0) begin
               n_checks++; if (t != last_t + 1) begin n_fail++; $display("FAIL cont_gap n=%0d at %0d want %0d", n, t, last_t + 1); end
            end
            last_t = t; n++;
         end
         @(posedge clk); #1;
      end
      n_checks++; if (n != 24) begin n_fail++; $display("FAIL cont_count got %0d want 24", n); end
      n_checks++; if (sof_cnt != 2) begin n_fail++; $display("FAIL cont_sof_cnt got %0d want 2", sof_cnt); end
      n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL cont_done_cnt got %0d want 2", done_cnt); end
   endtask

   task automatic test_mid_reset();
      int n;
      logic found;
      found = 1'b0; n = 0;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         #1;
         if (out_valid && out_pixel == 8'd6) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach6 got %b want 1", found); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rd_en got %b want 0", rd_en); end
      n_checks++; if (out_pixel !== 8'd0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
         n_fail++; $display("FAIL mid_outs got p=%0d s=%b e=%b want 0", out_pixel, out_sof, out_eol);
      end
      n_checks++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL mid_addr got %0d want 0", rd_addr); end
      n_checks++; if (out_valid_c !== 1'b0) begin n_fail++; $display("FAIL mid_valid_c got %b want 0", out_valid_c); end
      #3 reset = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         #1;
         if (out_valid && out_ready) begin
            n_checks++; if (out_pixel !== n[7:0]) begin n_fail++; $display("FAIL mid_pixel got %0d want %0d", out_pixel, n); end
            n_checks++; if (out_sof !== (n == 0)) begin n_fail++; $display("FAIL mid_sof n=%0d got %b", n, out_sof); end
            n++;
         end
         @(posedge clk); #1;
      end
      n_checks++; if (n != 12) begin n_fail++; $display("FAIL mid_count got %0d want 12", n); end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_backpressure();
      test_stall_start();
      test_start_ignored();
      test_continuous();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
